gpio_uart_tx: RTL and testbench
===============================

GPIO_UART_TX -- requirements
Module: gpio_uart_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 434, giving clock cycles per UART bit (50 MHz / 115200); legal range 2..65535.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, giving the number of 32-bit words buffered; power of two, 2..16.
REQ-003 The block SHALL have port CLK, input, 1, the single system clock; all logic on its rising edge.
REQ-004 The block SHALL have port RST, input, 1, reset, asynchronous and active-high.
REQ-005 The block SHALL have port GPIO, input, 32, the CPU GPIO output word being monitored.
REQ-006 The block SHALL have port TX, output, 1, the UART serial line, idle high.
REQ-007 The block SHALL have port BUSY, output, 1, high while a frame is in progress or the FIFO is non-empty.
REQ-008 The block SHALL have port OVERFLOW, output, 1, sticky flag set when a GPIO change is dropped because the FIFO is full.

Function
REQ-009 The block SHALL hold register LAST (32 bits); on any edge where GPIO != LAST, it SHALL load LAST <= GPIO and push GPIO into the FIFO in that same edge.
REQ-010 The block SHALL drop a push when the FIFO is full and no pop occurs on the same edge; on a drop it SHALL set OVERFLOW and still update LAST.
REQ-011 A simultaneous push and pop on a full FIFO SHALL succeed, with occupancy unchanged.
REQ-012 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL use a counter one bit wider than the pointers, and full/empty SHALL derive from that counter.
REQ-013 The transmit FSM SHALL have states IDLE, START, DATA and STOP.
REQ-014 In IDLE with a non-empty FIFO, the FSM SHALL pop the head word into a 32-bit shift register, set byte index 0, and enter START on that edge.
REQ-015 A word entering an empty FIFO at edge k while the FSM is IDLE SHALL be popped at edge k+1, with TX low from edge k+1.
REQ-016 START SHALL drive TX=0 for CLKS_PER_BIT cycles, then enter DATA.
REQ-017 DATA SHALL send 8 bits LSB first, each held CLKS_PER_BIT cycles, then enter STOP.
REQ-018 STOP SHALL drive TX=1 for CLKS_PER_BIT cycles.
REQ-019 Each word SHALL be sent as 4 bytes, least-significant byte first.
REQ-020 At the end of STOP, the FSM SHALL go to START if byte index < 3 (incrementing the index), otherwise to IDLE.
REQ-021 A full word SHALL occupy exactly 40*CLKS_PER_BIT cycles.
REQ-022 There SHALL be no idle gap between bytes of one word; back-to-back words SHALL have exactly 1 IDLE cycle between them.
REQ-023 The baud counter SHALL count 0..CLKS_PER_BIT-1 and wrap to 0 on each bit boundary; the bit counter SHALL count 0..7.
REQ-024 GPIO changes arriving during transmission SHALL only affect the FIFO, never the word in flight.
REQ-025 OVERFLOW SHALL be cleared only by RST.

Reset
REQ-026 RST asserted SHALL immediately force: TX=1, BUSY=0, OVERFLOW=0, LAST=0, FIFO empty, FSM=IDLE, all counters 0.
REQ-027 Reset during a frame SHALL abort it; no partial byte SHALL resume after release.
REQ-028 On the first edge after reset release, a non-zero GPIO SHALL be pushed, because LAST=0.

Structure
REQ-029 Shared package gpio_uart_pkg SHALL hold the FSM state encoding (IDLE=0, START=1, DATA=2, STOP=3) and the default CLKS_PER_BIT constant.
REQ-030 The FIFO SHALL be a separate sub-module, sync_fifo32, parameterised by depth, with push/pop/full/empty ports.
REQ-031 gpio_uart_tx SHALL be instantiated beside Main, with GPIO driven by Main's GPIO output.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-032 Release reset with GPIO=0 and hold for 200 cycles -> TX stays 1, BUSY=0, OVERFLOW=0.
REQ-033 Set GPIO=0x11223344 for one edge, then hold it -> TX shows bytes 0x44, 0x33, 0x22, 0x11, each as 0 + LSB-first data + 1 in 4-cycle bits; total 160 cycles; BUSY then falls.
REQ-034 Change GPIO on 6 consecutive cycles (values 1..6) while idle -> word 1 is popped at once, 2..5 fill the FIFO, 6 is dropped with OVERFLOW=1; TX emits words 1..5 in order, each 160 cycles with 1-cycle gaps.
REQ-035 Change GPIO on the exact edge the FSM pops from a full FIFO -> no drop, OVERFLOW stays 0.
REQ-036 Assert RST mid-DATA of byte 2 -> TX=1 within the same cycle, FIFO empty; after release, the current non-zero GPIO is re-sent as a complete fresh word.
REQ-037 Hold GPIO constant at 0xA5A5A5A5 after its word completes -> no further transmission.

Source files
------------

// File: rtl/gpio_uart_pkg.sv
// Shared definitions for the GPIO-change UART transmitter: FSM encoding and baud default.
package gpio_uart_pkg;

    localparam int CLKS_PER_BIT_DEFAULT = 434;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/gpio_uart_tx_fifo.sv
// 32-bit synchronous FIFO; occupancy counter is one bit wider than the pointers.
module sync_fifo32 #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        full,
    output logic        empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]   FULL_CNT = (PW + 1)'(DEPTH);
    localparam logic [PW:0]   CNT_ONE  = (PW + 1)'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    // A pop frees a slot on the same edge, so a push into a full FIFO still lands.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (do_push && !do_pop)      count <= count + CNT_ONE;
            else if (do_pop && !do_push) count <= count - CNT_ONE;
        end
    end

endmodule

// File: rtl/gpio_uart_tx.sv
// Watches a 32-bit GPIO word and serialises every change as four 8N1 UART bytes, LSB byte first.
// state | meaning: IDLE wait for FIFO word | START start bit | DATA 8 data bits | STOP stop bit
module gpio_uart_tx
    import gpio_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] GPIO,
    output logic        TX,
    output logic        BUSY,
    output logic        OVERFLOW
);

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    tx_state_t   state_q;
    tx_state_t   state_d;
    logic [31:0] last_q;
    logic [31:0] shreg_q;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_cnt;
    logic [1:0]  byte_idx;
    logic        overflow_q;
    logic        push;
    logic        pop;
    logic        full;
    logic        empty;
    logic        bit_done;
    logic        tx_d;
    logic [31:0] head_word;

    sync_fifo32 #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (CLK),
        .rst     (RST),
        .push    (push),
        .pop     (pop),
        .wr_data (GPIO),
        .rd_data (head_word),
        .full    (full),
        .empty   (empty)
    );

    assign push     = (GPIO != last_q);
    assign bit_done = (baud_cnt == BAUD_LAST);
    assign TX       = tx_d;
    assign BUSY     = (state_q != IDLE) || !empty;
    assign OVERFLOW = overflow_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        tx_d    = 1'b1;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (bit_done) state_d = DATA;
            end
            DATA: begin
                tx_d = shreg_q[0];
                if (bit_done && bit_cnt == 3'd7) state_d = STOP;
            end
            STOP: begin
                if (bit_done) state_d = (byte_idx == 2'd3) ? IDLE : START;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            last_q     <= '0;
            overflow_q <= 1'b0;
            shreg_q    <= '0;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            byte_idx   <= '0;
        end else begin
            if (push) last_q <= GPIO;
            if (push && full && !pop) overflow_q <= 1'b1;

            if (pop) begin
                shreg_q  <= head_word;
                baud_cnt <= '0;
                bit_cnt  <= '0;
                byte_idx <= '0;
            end else if (state_q != IDLE) begin
                baud_cnt <= bit_done ? '0 : baud_cnt + 16'd1;
                // Shifting the whole word brings the next byte into [7:0] after 8 bits.
                if (state_q == DATA && bit_done) begin
                    shreg_q <= shreg_q >> 1;
                    bit_cnt <= bit_cnt + 3'd1;
                end
                if (state_q == STOP && bit_done && byte_idx != 2'd3) begin
                    byte_idx <= byte_idx + 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_gpio_uart_tx.sv
// Scoreboard bench: stimulus queues expected bytes, a UART monitor on TX decodes and checks them.
module tb_gpio_uart_tx;

    typedef struct {
        logic [7:0] data;
        int         gap;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] gpio = 32'h0;
    logic        tx;
    logic        busy;
    logic        overflow;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          mon_st = 0;
    int          s_cyc = 0;
    int          last_start = 0;
    int          ph = 0;
    logic [7:0]  sh = 8'h0;

    gpio_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
        .CLK      (clk),
        .RST      (rst),
        .GPIO     (gpio),
        .TX       (tx),
        .BUSY     (busy),
        .OVERFLOW (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Byte b of a word starts 40 cycles after byte b-1; first_gap covers the word boundary.
    task automatic push_word(input logic [31:0] w, input int first_gap);
        for (int b = 0; b < 4; b++) begin
            exp_t e;
            e.data = w[8*b +: 8];
            e.gap  = (b == 0) ? first_gap : 40;
            exp_q.push_back(e);
        end
    endtask

    task automatic drive(input logic [31:0] v);
        @(negedge clk);
        gpio = v;
    endtask

    task automatic do_reset(input logic [31:0] v);
        @(negedge clk);
        rst  = 1'b1;
        gpio = v;
        #1;
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_drain(input int max_cyc);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || busy || mon_st != 0) && t < max_cyc) begin
            @(negedge clk);
            t++;
        end
        check("drain_in_time", 32'(t < max_cyc), 32'd1);
    endtask

    // UART decoder: mid-bit sampling at 4 clocks per bit, restarts on reset.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            mon_st = 0;
        end else if (mon_st == 0) begin
            if (!tx) begin
                s_cyc  = cyc;
                mon_st = 1;
            end
        end else begin
            ph = cyc - s_cyc;
            if (ph == 2) begin
                check("start_bit", 32'(tx), 32'd0);
            end else if (ph >= 6 && ph <= 34 && ((ph - 6) % 4) == 0) begin
                sh[3'((ph - 6) / 4)] = tx;
            end else if (ph == 38) begin
                check("stop_bit", 32'(tx), 32'd1);
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", 32'(sh), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("byte_data", 32'(sh), 32'(e.data));
                    if (e.gap != 0) check("byte_spacing", 32'(s_cyc - last_start), 32'(e.gap));
                end
                last_start = s_cyc;
                mon_st     = 0;
            end
        end
    end

    initial begin
        int cnt;
        int bad_tx;
        int bad_busy;
        int bad_ovf;

        // Idle after reset with GPIO=0: line stays quiet
        do_reset(32'h0);
        bad_tx = 0; bad_busy = 0; bad_ovf = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx !== 1'b1) bad_tx++;
            if (busy !== 1'b0) bad_busy++;
            if (overflow !== 1'b0) bad_ovf++;
        end
        check("idle_tx_low_cycles", 32'(bad_tx), 32'd0);
        check("idle_busy_cycles", 32'(bad_busy), 32'd0);
        check("idle_overflow_cycles", 32'(bad_ovf), 32'd0);

        // Single word: pop one edge after push, 160-cycle frame
        drive(32'h1122_3344);
        push_word(32'h1122_3344, 0);
        @(negedge clk);
        check("pre_pop_tx", 32'(tx), 32'd1);
        check("pre_pop_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("pop_latency_tx", 32'(tx), 32'd0);
        cnt = 0;
        while (busy && cnt < 400) begin
            cnt++;
            @(negedge clk);
        end
        check("word_busy_cycles", 32'(cnt), 32'd160);
        wait_drain(200);

        // Six consecutive changes: 1 popped, 2..5 buffered, 6 dropped
        for (int v = 1; v <= 6; v++) begin
            if (v == 6) begin
                @(negedge clk);
                check("overflow_before_drop", 32'(overflow), 32'd0);
                gpio = 32'(v);
            end else begin
                drive(32'(v));
            end
            if (v <= 5) push_word(32'(v), (v == 1) ? 0 : 41);
        end
        @(negedge clk);
        check("overflow_after_drop", 32'(overflow), 32'd1);
        wait_drain(1200);
        check("overflow_sticky", 32'(overflow), 32'd1);

        // Change on the exact edge the FSM pops from a full FIFO
        do_reset(32'h0);
        for (int v = 1; v <= 5; v++) begin
            drive(32'(v));
            push_word(32'(v), (v == 1) ? 0 : 41);
        end
        repeat (158) @(negedge clk);
        gpio = 32'h77;
        push_word(32'h77, 41);
        @(negedge clk);
        check("overflow_on_pop_edge", 32'(overflow), 32'd0);
        wait_drain(1200);
        check("overflow_after_full_pop", 32'(overflow), 32'd0);

        // Reset mid-DATA of byte 2, then fresh resend of the held GPIO
        do_reset(32'hCAFE_F00D);
        push_word(32'hCAFE_F00D, 0);
        repeat (102) @(negedge clk);
        check("pre_abort_busy", 32'(busy), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("abort_tx", 32'(tx), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_remaining_bytes", 32'(exp_q.size()), 32'd2);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        push_word(32'hCAFE_F00D, 0);
        wait_drain(300);

        // Constant GPIO after its word: no further traffic
        drive(32'hA5A5_A5A5);
        push_word(32'hA5A5_A5A5, 0);
        wait_drain(300);
        bad_tx = 0; bad_busy = 0;
        repeat (300) begin
            @(negedge clk);
            if (tx !== 1'b1) bad_tx++;
            if (busy !== 1'b0) bad_busy++;
        end
        check("hold_tx_low_cycles", 32'(bad_tx), 32'd0);
        check("hold_busy_cycles", 32'(bad_busy), 32'd0);
        check("queue_empty_at_end", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
